// File: rtl/dadda_mult_pipe_if.sv
// Handshake bundle for the pipelined Dadda multiplier: operand request in, product response out.
interface dadda_mult_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/dadda_mult_pipe.sv
// 3-stage signed/unsigned multiplier: S1 Baugh-Wooley partial products, S2 Dadda-reduced
// sum/carry rows, S3 carry-propagate product. Valid/ready with per-stage stall.
module dadda_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst,
  dadda_mult_pipe_if.slave io
);
  localparam int COLS = 2 * WIDTH;
  localparam int MAXH = WIDTH + 1;

  function automatic int dadda_h(input int k);
    case (k)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 9;
      5:       return 13;
      6:       return 19;
      default: return 28;
    endcase
  endfunction

  logic [3:1]                        vld_pipe;
  logic                              adv1, adv2, adv3;
  logic [WIDTH-1:0][WIDTH-1:0]       pp, s1_pp;
  logic                              s1_sgn;
  logic [TAG_W-1:0]                  s1_tag, s2_tag, s3_tag;
  logic [COLS-1:0]                   row0, row1, s2_row0, s2_row1, s3_prod;

  // A stage may load when empty or when its content leaves on the same edge.
  assign adv3           = !vld_pipe[3] || io.out_ready;
  assign adv2           = !vld_pipe[2] || adv3;
  assign adv1           = !vld_pipe[1] || adv2;
  assign io.in_ready    = adv1;
  assign io.out_valid   = vld_pipe[3];
  assign io.out_product = s3_prod;
  assign io.out_tag     = s3_tag;

  // Row i = multiplier bit i, column j = multiplicand bit j, weight i+j.
  // In signed mode the MSB row/column terms (except the corner) are inverted.
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        pp[i][j] = (io.in_a[j] & io.in_b[i]) ^
                   (io.in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
  end

  always_comb begin : dadda
    logic [MAXH-1:0] cur [COLS];
    logic [MAXH-1:0] nxt [COLS];
    int              ccnt [COLS];
    int              ncnt [COLS];
    int              h, p, d;
    h = 0; p = 0; d = 0;
    for (int c = 0; c < COLS; c++) begin
      cur[c] = '0; nxt[c] = '0; ccnt[c] = 0; ncnt[c] = 0;
    end
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        cur[i+j][ccnt[i+j]] = s1_pp[i][j];
        ccnt[i+j]++;
      end
    // Baugh-Wooley correction ones, present only for signed operations.
    cur[WIDTH][ccnt[WIDTH]] = s1_sgn;
    ccnt[WIDTH]++;
    cur[COLS-1][ccnt[COLS-1]] = s1_sgn;
    ccnt[COLS-1]++;
    // Stages whose target is above the current height degenerate to a copy.
    for (int k = 7; k >= 0; k--) begin
      d = dadda_h(k);
      for (int c = 0; c < COLS; c++) begin
        nxt[c] = '0; ncnt[c] = 0;
      end
      for (int c = 0; c < COLS; c++) begin
        p = 0;
        h = ccnt[c] + ncnt[c];
        for (int r = 0; r < MAXH; r++) begin
          if (h >= d + 2 && ccnt[c] - p >= 3) begin
            nxt[c][ncnt[c]] = cur[c][p] ^ cur[c][p+1] ^ cur[c][p+2];
            ncnt[c]++;
            if (c + 1 < COLS) begin
              nxt[c+1][ncnt[c+1]] = (cur[c][p] & cur[c][p+1]) |
                                    (cur[c][p] & cur[c][p+2]) |
                                    (cur[c][p+1] & cur[c][p+2]);
              ncnt[c+1]++;
            end
            p = p + 3;
            h = h - 2;
          end else if (h == d + 1 && ccnt[c] - p >= 2) begin
            nxt[c][ncnt[c]] = cur[c][p] ^ cur[c][p+1];
            ncnt[c]++;
            if (c + 1 < COLS) begin
              nxt[c+1][ncnt[c+1]] = cur[c][p] & cur[c][p+1];
              ncnt[c+1]++;
            end
            p = p + 2;
            h = h - 1;
          end
        end
        for (int r = 0; r < MAXH; r++)
          if (r >= p && r < ccnt[c]) begin
            nxt[c][ncnt[c]] = cur[c][r];
            ncnt[c]++;
          end
      end
      cur  = nxt;
      ccnt = ncnt;
    end
    for (int c = 0; c < COLS; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_pp    <= '0;
      s1_sgn   <= 1'b0;
      s1_tag   <= '0;
      s2_row0  <= '0;
      s2_row1  <= '0;
      s2_tag   <= '0;
      s3_prod  <= '0;
      s3_tag   <= '0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= io.in_valid;
        if (io.in_valid) begin
          s1_pp  <= pp;
          s1_sgn <= io.in_signed;
          s1_tag <= io.in_tag;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s2_row0 <= row0;
          s2_row1 <= row1;
          s2_tag  <= s1_tag;
        end
      end
      if (adv3) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) begin
          s3_prod <= s2_row0 + s2_row1;
          s3_tag  <= s2_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Directed + randomized check of dadda_mult_pipe at WIDTH=16: latency, corners, stall, reset, ordering.
module tb_dadda_mult_pipe;
  localparam int W  = 16;
  localparam int TW = 4;

  typedef struct {
    logic [2*W-1:0] p;
    logic [TW-1:0]  t;
    int             cyc;
  } res_t;

  logic clk, rst;
  logic rnd_rdy, rdy_fix, rnd_bit;
  int   checks, errors, cyc;
  res_t got_q[$];
  res_t exp_q[$];

  dadda_mult_pipe_if #(.WIDTH(W), .TAG_W(TW)) io ();

  dadda_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  assign io.out_ready = rnd_rdy ? rnd_bit : rdy_fix;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial rnd_bit = 1'b1;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Transfers are decided at the next rising edge from values stable at the falling edge.
  always @(negedge clk)
    if (!rst && io.out_valid && io.out_ready)
      got_q.push_back('{p: io.out_product, t: io.out_tag, cyc: cyc});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] t, output int n);
    logic r;
    n = 0;
    r = 1'b0;
    io.in_valid = 1'b1; io.in_a = a; io.in_b = b; io.in_signed = s; io.in_tag = t;
    do begin
      @(negedge clk);
      r = io.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    io.in_valid = 1'b0;
    if (!r) chk("send_timeout", 0, 1);
  endtask

  task automatic drain(input int want);
    int n;
    n = 0;
    while (got_q.size() < want && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (got_q.size() < want) chk("drain_timeout", got_q.size(), want);
  endtask

  logic [W-1:0]    bp_a [5] = '{16'h0003, 16'hFFFF, 16'd100, 16'h8000, 16'h1234};
  logic [W-1:0]    bp_b [5] = '{16'h0005, 16'h0002, 16'd200, 16'h0001, 16'h0010};
  logic            bp_s [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2*W-1:0]  bp_p [5] = '{32'h0000000F, 32'hFFFFFFFE, 32'h00004E20, 32'hFFFF8000, 32'h00012340};

  initial begin
    int n, acc;
    logic [W-1:0] ra, rb;
    logic rs;
    logic [TW-1:0] rt;
    checks = 0; errors = 0;
    rst = 1'b1; rnd_rdy = 1'b0; rdy_fix = 1'b1;
    io.in_valid = 1'b0; io.in_a = '0; io.in_b = '0; io.in_signed = 1'b0; io.in_tag = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_product", io.out_product, 0);
    chk("rst_tag", io.out_tag, 0);
    rst = 1'b0;

    // Unsigned max, latency 3 register stages.
    send(16'hFFFF, 16'hFFFF, 1'b0, 4'h3, n);
    chk("first_accept_edge", n, 1);
    chk("lat_v0", io.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_v1", io.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_v2", io.out_valid, 1);
    chk("umax_prod", io.out_product, 32'hFFFE0001);
    chk("umax_tag", io.out_tag, 4'h3);
    drain(1);
    got_q.delete();

    // Signed corners back to back.
    send(16'hFFFF, 16'hFFFF, 1'b1, 4'h1, n);
    send(16'h8000, 16'h8000, 1'b1, 4'h2, n);
    send(16'h8000, 16'h7FFF, 1'b1, 4'h3, n);
    drain(3);
    if (got_q.size() == 3) begin
      chk("sc0_prod", got_q[0].p, 32'h00000001);
      chk("sc1_prod", got_q[1].p, 32'h40000000);
      chk("sc2_prod", got_q[2].p, 32'hC0008000);
      chk("sc2_tag", got_q[2].t, 4'h3);
      chk("sc_consec01", got_q[1].cyc - got_q[0].cyc, 1);
      chk("sc_consec12", got_q[2].cyc - got_q[1].cyc, 1);
    end else chk("sc_count", got_q.size(), 3);
    got_q.delete();

    // Backpressure: out_ready low for 4 cycles while streaming 5 operations.
    rdy_fix = 1'b0;
    acc = 0;
    io.in_valid = 1'b1; io.in_a = bp_a[0]; io.in_b = bp_b[0];
    io.in_signed = bp_s[0]; io.in_tag = 4'(1);
    for (int t = 0; t < 4; t++) begin
      logic r;
      @(negedge clk);
      r = io.in_ready;
      @(posedge clk); #1;
      if (r) begin
        acc++;
        io.in_a = bp_a[acc]; io.in_b = bp_b[acc]; io.in_signed = bp_s[acc]; io.in_tag = 4'(acc + 1);
      end
      if (t == 2) chk("bp_prod_t2", io.out_product, bp_p[0]);
    end
    io.in_valid = 1'b0;
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready_low", io.in_ready, 0);
    chk("bp_out_valid", io.out_valid, 1);
    chk("bp_prod_stable", io.out_product, bp_p[0]);
    chk("bp_tag_stable", io.out_tag, 4'h1);
    rdy_fix = 1'b1;
    for (int i = acc; i < 5; i++) send(bp_a[i], bp_b[i], bp_s[i], 4'(i + 1), n);
    drain(5);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      chk($sformatf("bp_prod%0d", i), got_q[i].p, bp_p[i]);
      chk($sformatf("bp_tag%0d", i), got_q[i].t, 4'(i + 1));
    end
    got_q.delete();

    // Reset mid-flight discards everything in the pipe.
    send(16'h0007, 16'h0009, 1'b0, 4'hA, n);
    send(16'h0011, 16'h0003, 1'b0, 4'hB, n);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", io.out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", io.in_ready, 1);
    chk("post_rst_prod", io.out_product, 0);
    send(16'h0006, 16'h0007, 1'b0, 4'hC, n);
    chk("post_rst_first_edge", n, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_count", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("post_rst_prod_new", got_q[0].p, 32'd42);
      chk("post_rst_tag_new", got_q[0].t, 4'hC);
    end
    got_q.delete();

    // Random operands, random downstream stall.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      rt = 4'(i);
      exp_q.push_back('{p: ref_mul(ra, rb, rs), t: rt, cyc: 0});
      send(ra, rb, rs, rt, n);
    end
    drain(2000);
    rnd_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("rnd_prod%0d", i), got_q[i].p, exp_q[i].p);
      chk($sformatf("rnd_tag%0d", i), got_q[i].t, exp_q[i].t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
